// File: rtl/mux_rr_stream.sv
// N-channel W-bit stream mux: fixed select or round-robin, registered output.
// Latency: 1 cycle from the input handshake to OUT_VALID with the data.
// Backpressure: IN_READY follows the output register's free/draining state, so there are no bubbles.
//
// Ports:
//   CLK, RST       clock, asynchronous active-high reset
//   IN_DATA        N*W packed channel data, channel i at [i*W +: W]
//   IN_VALID       per-channel valid
//   IN_READY       per-channel ready, at most one bit high (the granted channel)
//   MODE           0 = fixed select via S, 1 = round-robin
//   S              channel select for fixed mode; values >= N never grant
//   OUT, OUT_CH    registered data and the index of the channel that produced it
//   OUT_VALID      OUT holds a word not yet accepted
//   OUT_READY      consumer accepts OUT this cycle
module mux_rr_stream #(
  parameter int W  = 8,
  parameter int N  = 8,
  parameter int SW = 3
) (
  input  logic           CLK,
  input  logic           RST,
  input  logic [N*W-1:0] IN_DATA,
  input  logic [N-1:0]   IN_VALID,
  output logic [N-1:0]   IN_READY,
  input  logic           MODE,
  input  logic [SW-1:0]  S,
  output logic [W-1:0]   OUT,
  output logic           OUT_VALID,
  input  logic           OUT_READY,
  output logic [SW-1:0]  OUT_CH
);

  logic [W-1:0]  out_q,     out_d;
  logic          out_vld_q, out_vld_d;
  logic [SW-1:0] out_ch_q,  out_ch_d;
  logic [SW-1:0] ptr_q,     ptr_d;

  logic          load_en;
  logic          gnt_vld;
  logic [SW-1:0] gnt_idx;
  logic [W-1:0]  gnt_dat;
  logic          xfer;
  logic [N-1:0]  in_ready;

  // Register is free when empty, or when its current word leaves this cycle.
  assign load_en = !out_vld_q || OUT_READY;

  // Grant selection.
  // Round-robin: channels at or above PTR come first in scan order, then those
  // below it. Each loop runs high-to-low so the lowest index in a group wins,
  // and the second loop overrides the first so the >= PTR group has priority.
  always_comb begin
    gnt_vld = 1'b0;
    gnt_idx = '0;
    if (!MODE) begin
      for (int i = 0; i < N; i++) begin
        if (S == SW'(i) && IN_VALID[i]) begin
          gnt_vld = 1'b1;
          gnt_idx = SW'(i);
        end
      end
    end else begin
      for (int i = N - 1; i >= 0; i--) begin
        if (IN_VALID[i] && (SW'(i) < ptr_q)) begin
          gnt_vld = 1'b1;
          gnt_idx = SW'(i);
        end
      end
      for (int i = N - 1; i >= 0; i--) begin
        if (IN_VALID[i] && (SW'(i) >= ptr_q)) begin
          gnt_vld = 1'b1;
          gnt_idx = SW'(i);
        end
      end
    end
  end

  assign xfer = gnt_vld && load_en && !RST;

  // Data select and one-hot ready; data only feeds the register, never an output.
  always_comb begin
    gnt_dat  = '0;
    in_ready = '0;
    for (int i = 0; i < N; i++) begin
      if (gnt_idx == SW'(i)) begin
        gnt_dat     = IN_DATA[i*W +: W];
        in_ready[i] = xfer;
      end
    end
  end

  assign IN_READY = in_ready;

  // Next-state for the output register and round-robin pointer.
  always_comb begin
    out_d     = out_q;
    out_vld_d = out_vld_q;
    out_ch_d  = out_ch_q;
    ptr_d     = ptr_q;
    if (xfer) begin
      out_d     = gnt_dat;
      out_ch_d  = gnt_idx;
      out_vld_d = 1'b1;
      if (MODE) begin
        ptr_d = (gnt_idx == SW'(N - 1)) ? '0 : gnt_idx + SW'(1);
      end
    end else if (load_en) begin
      // Drained (or already empty) with nothing to replace it.
      out_vld_d = 1'b0;
    end
  end

  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      out_q     <= '0;
      out_vld_q <= 1'b0;
      out_ch_q  <= '0;
      ptr_q     <= '0;
    end else begin
      out_q     <= out_d;
      out_vld_q <= out_vld_d;
      out_ch_q  <= out_ch_d;
      ptr_q     <= ptr_d;
    end
  end

  assign OUT       = out_q;
  assign OUT_VALID = out_vld_q;
  assign OUT_CH    = out_ch_q;

endmodule

// File: doc/mux_rr_stream.md
# mux_rr_stream

Parametrised N-channel, W-bit stream multiplexer with a registered output stage and valid/ready handshakes on every channel. It selects one input channel per cycle, either by an explicit select input (fixed mode) or by a round-robin arbiter (round-robin mode). It is the next generation of the team's combinational 8:1 byte mux, placed between several producers and a single shared consumer.

## Interface
- W, default 8: data width per channel.
- N, default 8: number of input channels, 2..16.
- SW, default 3: select/index width, ceil(log2 N), at least 1.

- CLK  in  1  clock; all state changes on the rising edge.
- RST  in  1  reset, asynchronous, active-high.
- IN_DATA  in  N*W  channel i occupies bits [i*W +: W].
- IN_VALID  in  N  per-channel valid.
- IN_READY  out  N  per-channel ready; at most one bit high.
- MODE  in  1  0 = fixed select via S; 1 = round-robin.
- S  in  SW  channel select, used only when MODE = 0.
- OUT  out  W  registered output data.
- OUT_VALID  out  1  OUT holds a word not yet accepted.
- OUT_READY  in  1  consumer accepts OUT this cycle.
- OUT_CH  out  SW  index of the channel that produced OUT.

## Operation
- Output register: OUT, OUT_VALID, OUT_CH. Internal round-robin pointer PTR (SW bits, range 0..N-1).
- load_en = !OUT_VALID || OUT_READY. The register can take a new word when it is empty or is being drained in the same cycle.
- Grant, combinational:
  - MODE = 0: grant channel S if S < N and IN_VALID[S]. Otherwise no grant. S >= N never grants.
  - MODE = 1: grant the first channel with IN_VALID high, scanning PTR, PTR+1, ... N-1, 0, ... PTR-1 (mod N). No grant if no channel is valid.
- IN_READY[g] = load_en for the granted channel g. All other IN_READY bits are 0.
- A transfer happens when IN_VALID[g] && IN_READY[g]. On the next edge: OUT <= IN_DATA[g], OUT_CH <= g, OUT_VALID <= 1.
- If load_en is high, OUT_READY is high and there is no grant: OUT_VALID <= 0. OUT and OUT_CH hold their last values.
- If load_en is low (OUT_VALID=1, OUT_READY=0): OUT, OUT_CH and OUT_VALID hold exactly.
- PTR update: on a transfer in MODE = 1, PTR <= (g+1) mod N, wrapping from N-1 to 0. In MODE = 0, PTR is unchanged.
- A MODE change takes effect in the same cycle. PTR is retained across mode changes.
- Input data is never dropped or duplicated. Each accepted word appears on OUT exactly once.

## Timing
- Reset values (asynchronous, held while RST=1): OUT=0, OUT_VALID=0, OUT_CH=0, PTR=0. All IN_READY bits = 0 while RST=1.
- Latency: input handshake at edge k gives OUT_VALID=1 with that data after edge k.
- Throughput: one word per cycle when OUT_READY is held high.
- IN_READY depends combinationally on OUT_READY, OUT_VALID, MODE, S, IN_VALID and PTR. There is no combinational path from IN_DATA to any output.
- Simultaneous drain and load (OUT_VALID=1, OUT_READY=1, grant present): the new word replaces the old one in the same edge, with no bubble.
- Round-robin fairness: with all N channels valid and OUT_READY=1, each channel is granted exactly once in every N consecutive transfers.
- Reset asserted mid-stream: the word in the output register is discarded, PTR returns to 0, and the first grant after reset in MODE=1 goes to the lowest-index valid channel.
- Inputs must be stable around the rising CLK edge. RST release is synchronous to CLK by system design.

## Test plan
- Reset: assert RST with all IN_VALID=1 and OUT_READY=1 -> OUT=0, OUT_VALID=0, OUT_CH=0, IN_READY=0. Release, MODE=1 -> first OUT from channel 0, then channel 1.
- Fixed mode: MODE=0, S=3, channel i data = 8'h10+i, all valid, OUT_READY=1 -> OUT=8'h13 and OUT_CH=3 every cycle; only IN_READY[3]=1. Change S to 6 -> next OUT=8'h16.
- Round-robin wrap: MODE=1, all 8 channels valid, OUT_READY=1 for 10 cycles -> OUT_CH sequence 0,1,2,3,4,5,6,7,0,1 with no gap cycles.
- Sparse valid: MODE=1, IN_VALID=8'b1000_0100, PTR=0 -> grants 2, 7, 2, 7. Then drop channel 7 -> only 2 is granted, and PTR advances to 3 after each transfer.
- Backpressure: OUT_VALID=1, OUT_READY=0 for 4 cycles -> OUT and OUT_CH stable and all IN_READY=0. Raise OUT_READY -> the next word loads on the same edge, with no bubble.
- Out-of-range select: N=5, SW=3, MODE=0, S=6, all valid -> no IN_READY high. The output drains to OUT_VALID=0 and stays empty.
